// File: rtl/gshare_bpt_if.sv
// Fetch-side lookup and resolution-side update signals of the gshare predictor.
// The BPT_STATS_EN macro adds the statistics counters to the bundle.
interface gshare_bpt_if #(
  parameter int unsigned GHR_BITS = 10
) ();
  logic                fetch_br;
  logic [31:0]         pc_fetch;
  logic                pred_fetch;
  logic [GHR_BITS-1:0] ghr_fetch;
  logic                enable_res;
  logic [31:0]         pc_res;
  logic [GHR_BITS-1:0] ghr_res;
  logic                taken_res;
  logic                pred_correct;
  logic                mispredict;
`ifdef BPT_STATS_EN
  logic [31:0]         stat_lookups;
  logic [31:0]         stat_mispred;
`endif

  modport master (
    output fetch_br, pc_fetch, enable_res, pc_res, ghr_res, taken_res,
    input  pred_fetch, ghr_fetch, pred_correct, mispredict
`ifdef BPT_STATS_EN
    , input stat_lookups, stat_mispred
`endif
  );

  modport slave (
    input  fetch_br, pc_fetch, enable_res, pc_res, ghr_res, taken_res,
    output pred_fetch, ghr_fetch, pred_correct, mispredict
`ifdef BPT_STATS_EN
    , output stat_lookups, stat_mispred
`endif
  );
endinterface

// File: rtl/gshare_bpt.sv
// Gshare branch predictor: saturating counters indexed by PC ^ speculative GHR,
// with GHR repair on mispredict. Define BPT_STATS_EN for lookup/mispredict counters.
module gshare_bpt #(
  parameter int unsigned INDEX_BITS = 10,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned GHR_BITS   = 10
) (
  input  logic          CLK,
  input  logic          nRST,
  gshare_bpt_if.slave   bpt
);

  localparam int unsigned         DEPTH    = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((32'd1 << (CTR_BITS - 1)) - 32'd1);

  logic [CTR_BITS-1:0]   ctr [DEPTH];
  logic [GHR_BITS-1:0]   ghr_spec;
  logic [GHR_BITS-1:0]   ghr_next;
  logic [GHR_BITS-1:0]   ghr_fetch_shift;
  logic [GHR_BITS-1:0]   ghr_res_shift;
  logic [INDEX_BITS-1:0] idx_fetch;
  logic [INDEX_BITS-1:0] idx_res;
  logic [CTR_BITS-1:0]   ctr_fetch;
  logic [CTR_BITS-1:0]   ctr_res;
  logic [CTR_BITS-1:0]   ctr_res_next;
  logic                  unused_pc_bits;

  // History occupies the low GHR_BITS of the index; upper bits come from PC alone.
  assign idx_fetch = bpt.pc_fetch[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_spec);
  assign idx_res   = bpt.pc_res[INDEX_BITS+1:2]   ^ INDEX_BITS'(bpt.ghr_res);

  assign unused_pc_bits = ^{bpt.pc_fetch[31:INDEX_BITS+2], bpt.pc_fetch[1:0],
                            bpt.pc_res[31:INDEX_BITS+2],   bpt.pc_res[1:0]};

  assign ctr_fetch = ctr[idx_fetch];
  assign ctr_res   = ctr[idx_res];

  assign bpt.pred_fetch   = ctr_fetch[CTR_BITS-1];
  assign bpt.ghr_fetch    = ghr_spec;
  assign bpt.pred_correct = (ctr_res[CTR_BITS-1] == bpt.taken_res);
  assign bpt.mispredict   = bpt.enable_res & ~bpt.pred_correct;

  // A one-bit history has nothing to shift, so it simply loads the new outcome.
  generate
    if (GHR_BITS == 1) begin : g_ghr_load
      assign ghr_fetch_shift = bpt.pred_fetch;
      assign ghr_res_shift   = bpt.taken_res;
    end else begin : g_ghr_shift
      assign ghr_fetch_shift = {ghr_spec[GHR_BITS-2:0], bpt.pred_fetch};
      assign ghr_res_shift   = {bpt.ghr_res[GHR_BITS-2:0], bpt.taken_res};
    end
  endgenerate

  always_comb begin
    ctr_res_next = ctr_res;
    if (bpt.taken_res) begin
      if (ctr_res != CTR_MAX) ctr_res_next = ctr_res + 1'b1;
    end else begin
      if (ctr_res != '0) ctr_res_next = ctr_res - 1'b1;
    end
  end

  always_comb begin
    ghr_next = ghr_spec;
    if (bpt.mispredict) begin
      ghr_next = ghr_res_shift;
    end else if (bpt.fetch_br) begin
      ghr_next = ghr_fetch_shift;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ghr_spec <= '0;
    end else begin
      ghr_spec <= ghr_next;
    end
  end

  // Fetch reads the pre-update value in a collision; the write lands at the edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ctr[i] <= CTR_INIT;
      end
    end else if (bpt.enable_res) begin
      ctr[idx_res] <= ctr_res_next;
    end
  end

`ifdef BPT_STATS_EN
  logic [31:0] lookups_q;
  logic [31:0] mispred_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lookups_q <= '0;
      mispred_q <= '0;
    end else begin
      if (bpt.fetch_br)   lookups_q <= lookups_q + 32'd1;
      if (bpt.mispredict) mispred_q <= mispred_q + 32'd1;
    end
  end

  assign bpt.stat_lookups = lookups_q;
  assign bpt.stat_mispred = mispred_q;
`endif

endmodule

// File: tb/tb_gshare_bpt.sv
// Directed, table-driven bench for gshare_bpt (INDEX_BITS=10, CTR_BITS=2, GHR_BITS=10);
// BPT_STATS_EN additionally checks the statistics counters.
module tb_gshare_bpt;

  logic CLK;
  logic nRST;

  gshare_bpt_if #(.GHR_BITS(10)) bpt ();

  gshare_bpt #(
    .INDEX_BITS(10),
    .CTR_BITS  (2),
    .GHR_BITS  (10)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bpt (bpt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        fbr;
    logic [31:0] pcf;
    logic        en;
    logic [31:0] pcr;
    logic [9:0]  ghr_r;
    logic        tk;
    logic        e_pred;
    logic [9:0]  e_ghr;
    logic        e_mis;
    logic        e_pc;
  } vec_t;

  vec_t vt[$];
  int   total;
  int   passed;

  function automatic vec_t mk(logic fbr, logic [31:0] pcf, logic en, logic [31:0] pcr,
                              logic [9:0] ghr_r, logic tk, logic e_pred, logic [9:0] e_ghr,
                              logic e_mis, logic e_pc);
    vec_t v;
    v.fbr = fbr; v.pcf = pcf; v.en = en; v.pcr = pcr; v.ghr_r = ghr_r; v.tk = tk;
    v.e_pred = e_pred; v.e_ghr = e_ghr; v.e_mis = e_mis; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s got %0h want %0h", name, got, want);
  endtask

  task automatic drive(input logic fbr, input logic [31:0] pcf, input logic en,
                       input logic [31:0] pcr, input logic [9:0] ghr_r, input logic tk);
    bpt.fetch_br   = fbr;
    bpt.pc_fetch   = pcf;
    bpt.enable_res = en;
    bpt.pc_res     = pcr;
    bpt.ghr_res    = ghr_r;
    bpt.taken_res  = tk;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    nRST   = 1'b0;
    drive(1'b0, 32'h100, 1'b0, 32'h0, 10'h0, 1'b0);

    //          fbr pcf           en pcr       ghr_r  tk   pred ghr    mis pc
    vt.push_back(mk(0, 32'h100,      0, 32'h000, 10'h0, 0,   0, 10'h0, 0, 0));
    vt.push_back(mk(0, 32'h100,      1, 32'h100, 10'h0, 1,   0, 10'h0, 1, 0));
    vt.push_back(mk(0, 32'h100,      1, 32'h100, 10'h0, 1,   0, 10'h1, 0, 1));
    vt.push_back(mk(0, 32'h104,      1, 32'h100, 10'h0, 1,   1, 10'h1, 0, 1));
    vt.push_back(mk(0, 32'h104,      1, 32'h100, 10'h0, 0,   1, 10'h1, 1, 0));
    vt.push_back(mk(0, 32'h100,      0, 32'h000, 10'h0, 0,   1, 10'h0, 0, 0));
    vt.push_back(mk(1, 32'h200,      0, 32'h000, 10'h0, 0,   0, 10'h0, 0, 0));
    vt.push_back(mk(1, 32'h204,      0, 32'h000, 10'h0, 0,   0, 10'h0, 0, 0));
    vt.push_back(mk(1, 32'h100,      0, 32'h000, 10'h0, 0,   1, 10'h0, 0, 0));
    vt.push_back(mk(0, 32'h104,      0, 32'h000, 10'h0, 0,   1, 10'h1, 0, 0));
    vt.push_back(mk(0, 32'h100,      0, 32'h000, 10'h0, 0,   0, 10'h1, 0, 0));
    vt.push_back(mk(1, 32'h104,      1, 32'h300, 10'h5, 1,   1, 10'h1, 1, 0));
    vt.push_back(mk(0, 32'h000,      0, 32'h000, 10'h0, 0,   0, 10'hB, 0, 0));
    vt.push_back(mk(0, 32'h000,      1, 32'h300, 10'h5, 1,   0, 10'hB, 0, 1));
    vt.push_back(mk(0, 32'h000,      0, 32'h000, 10'hB, 1,   0, 10'hB, 0, 0));
    vt.push_back(mk(0, 32'h000,      0, 32'h000, 10'h0, 0,   0, 10'hB, 0, 0));
    vt.push_back(mk(0, 32'h038,      1, 32'h014, 10'h0, 1,   0, 10'hB, 1, 0));
    vt.push_back(mk(0, 32'h010,      0, 32'h000, 10'h0, 0,   1, 10'h1, 0, 0));
    vt.push_back(mk(0, 32'hFFFFF013, 0, 32'h000, 10'h0, 0,   1, 10'h1, 0, 0));
    vt.push_back(mk(0, 32'h000,      0, 32'h000, 10'h0, 0,   0, 10'h1, 0, 0));

    #2;
    check("reset_pred", {31'd0, bpt.pred_fetch}, 32'd0);
    check("reset_ghr",  {22'd0, bpt.ghr_fetch},  32'd0);
    #10 nRST = 1'b1;

    foreach (vt[i]) begin
      @(posedge CLK);
      #1 drive(vt[i].fbr, vt[i].pcf, vt[i].en, vt[i].pcr, vt[i].ghr_r, vt[i].tk);
      #3;
      check($sformatf("v%0d_pred", i), {31'd0, bpt.pred_fetch}, {31'd0, vt[i].e_pred});
      check($sformatf("v%0d_ghr", i),  {22'd0, bpt.ghr_fetch},  {22'd0, vt[i].e_ghr});
      check($sformatf("v%0d_mis", i),  {31'd0, bpt.mispredict}, {31'd0, vt[i].e_mis});
      if (vt[i].en)
        check($sformatf("v%0d_pc", i), {31'd0, bpt.pred_correct}, {31'd0, vt[i].e_pc});
    end

    // Asynchronous reset in mid-operation clears history and counters at once.
    @(posedge CLK);
    #1 drive(1'b0, 32'h010, 1'b0, 32'h0, 10'h0, 1'b0);
    #1 check("pre_rst_pred", {31'd0, bpt.pred_fetch}, 32'd1);
    nRST = 1'b0;
    #1;
    check("async_rst_ghr",  {22'd0, bpt.ghr_fetch},  32'd0);
    check("async_rst_pred", {31'd0, bpt.pred_fetch}, 32'd0);
    bpt.pc_fetch = 32'h014;
    #1 check("async_rst_ctr5", {31'd0, bpt.pred_fetch}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    for (int k = 0; k < 4; k++) begin
      @(posedge CLK);
      #1 drive(1'b1, 32'h000, 1'b0, 32'h0, 10'h0, 1'b0);
    end
    @(posedge CLK);
    #1 drive(1'b0, 32'h000, 1'b1, 32'h000, 10'h0, 1'b1);
    #1 check("stats_seq_mis", {31'd0, bpt.mispredict}, 32'd1);
    @(posedge CLK);
    #1 drive(1'b0, 32'h000, 1'b0, 32'h0, 10'h0, 1'b0);
    #1 check("repair_ghr", {22'd0, bpt.ghr_fetch}, 32'd1);
`ifdef BPT_STATS_EN
    check("stat_lookups", bpt.stat_lookups, 32'd4);
    check("stat_mispred", bpt.stat_mispred, 32'd1);
    nRST = 1'b0;
    #1;
    check("stat_lookups_rst", bpt.stat_lookups, 32'd0);
    check("stat_mispred_rst", bpt.stat_mispred, 32'd0);
    nRST = 1'b1;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
